// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a first-word-fall-through byte FIFO and valid/ready read side.
// Mid-bit sampling is driven by a down-counting bit timer; bytes with a bad stop bit are dropped.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronised input
// START | timing half a bit to the middle of the start bit, glitch check
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | sampling the stop bit; push byte or flag a framing error
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ser_rx,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q;
    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic             frame_err_q, overrun_q;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic             sample, push_req, pop, push_ok, empty, full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= ser_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign sample   = (bit_cnt_q == '0);
    assign push_req = (state_q == STOP) && sample && rx_s_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        bit_cnt_q <= HALF_LOAD;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (!sample) begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end else if (rx_s_q) begin
                        state_q <= IDLE;
                    end else begin
                        bit_cnt_q <= FULL_LOAD;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (!sample) begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end else begin
                        shreg_q[bit_idx_q] <= rx_s_q;
                        bit_cnt_q          <= FULL_LOAD;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                STOP: begin
                    // Return to IDLE right at mid stop bit so a back-to-back start edge is not missed.
                    if (!sample) begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end else begin
                        frame_err_q <= !rx_s_q;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = rx_valid_o && rx_ready_i;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            overrun_q <= push_req && full && !pop;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rx_data_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid_o  = !empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule
